matrix2x2_stream_ctrl: RTL and testbench

Byte-stream front/back end for the 2x2 8-bit matrix multiplier. It collects eight matrix elements from an upstream valid/ready byte stream and packs them into the multiplier's 32-bit `a`/`b` operands. It then releases the multiplier's active-low reset, waits the fixed multiplier latency, and captures the packed 32-bit result. Finally it streams the four result bytes downstream over a valid/ready handshake.

---
 rtl/matrix2x2_stream_ctrl_if.sv | 27 ++
 rtl/matrix2x2_stream_ctrl.sv | 127 ++++++++++++
 tb/tb_matrix2x2_stream_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix2x2_stream_ctrl_if.sv
// Stream and multiplier bus for matrix2x2_stream_ctrl.
// master = controller side, slave = environment side.
interface matrix2x2_stream_ctrl_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] mat_a;
  logic [31:0] mat_b;
  logic        mat_rst_n;
  logic [31:0] mat_res;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        err;

  modport master (
    input  in_data, in_valid, mat_res, out_ready,
    output in_ready, mat_a, mat_b, mat_rst_n,
    output out_data, out_valid, err
  );

  modport slave (
    output in_data, in_valid, mat_res, out_ready,
    input  in_ready, mat_a, mat_b, mat_rst_n,
    input  out_data, out_valid, err
  );
endinterface

// File: rtl/matrix2x2_stream_ctrl.sv
// Byte-stream wrapper for the 2x2 8-bit matrix multiplier.
// Optional result self-check: define MATCTL_CHECK_EN.
module matrix2x2_stream_ctrl #(
  parameter int MUL_LAT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  matrix2x2_stream_ctrl_if.master bus
);
  localparam int WW = $clog2(MUL_LAT + 1) + 1;

  typedef enum logic [1:0] {
    LOAD,
    RUN,
    SEND
  } state_t;

  state_t      r_state;
  logic [2:0]  r_cnt;
  logic [WW-1:0] r_wait;
  logic [1:0]  r_ocnt;
  logic [63:0] r_ab;
  logic [31:0] r_res;
  logic        r_in_ready;
  logic        r_mat_rst_n;
  logic        r_out_valid;
  logic [7:0]  r_out_data;
  logic        w_err_set;

`ifdef MATCTL_CHECK_EN
  logic        r_err;
  logic [7:0]  w_a00, w_a01, w_a10, w_a11;
  logic [7:0]  w_b00, w_b01, w_b10, w_b11;
  logic [7:0]  w_r00, w_r01, w_r10, w_r11;

  assign {w_a00, w_a01, w_a10, w_a11} = r_ab[63:32];
  assign {w_b00, w_b01, w_b10, w_b11} = r_ab[31:0];
  // 8-bit context keeps only the mod-256 sum
  assign w_r00 = w_a00 * w_b00 + w_a01 * w_b10;
  assign w_r01 = w_a00 * w_b01 + w_a01 * w_b11;
  assign w_r10 = w_a10 * w_b00 + w_a11 * w_b10;
  assign w_r11 = w_a10 * w_b01 + w_a11 * w_b11;
  assign w_err_set =
    ({w_r00, w_r01, w_r10, w_r11} != bus.mat_res);
  assign bus.err = r_err;
`else
  assign w_err_set = 1'b0;
  assign bus.err   = 1'b0;
`endif

  assign bus.in_ready  = r_in_ready;
  assign bus.mat_a     = r_ab[63:32];
  assign bus.mat_b     = r_ab[31:0];
  assign bus.mat_rst_n = r_mat_rst_n;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= LOAD;
      r_cnt       <= '0;
      r_wait      <= '0;
      r_ocnt      <= '0;
      r_ab        <= '0;
      r_res       <= '0;
      r_in_ready  <= 1'b0;
      r_mat_rst_n <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
`ifdef MATCTL_CHECK_EN
      r_err       <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        LOAD: begin
          if (!r_in_ready) begin
            r_in_ready <= 1'b1;
          end else if (bus.in_valid) begin
            r_ab  <= {r_ab[55:0], bus.in_data};
            r_cnt <= r_cnt + 3'd1;
`ifdef MATCTL_CHECK_EN
            if (r_cnt == 3'd0) r_err <= 1'b0;
`endif
            if (r_cnt == 3'd7) begin
              r_in_ready  <= 1'b0;
              r_mat_rst_n <= 1'b1;
              r_wait      <= '0;
              r_state     <= RUN;
            end
          end
        end
        RUN: begin
          r_wait <= r_wait + 1'b1;
          if (r_wait == WW'(MUL_LAT)) begin
            r_res       <= bus.mat_res;
            r_out_data  <= bus.mat_res[31:24];
            r_out_valid <= 1'b1;
            r_mat_rst_n <= 1'b0;
            r_ocnt      <= '0;
            r_state     <= SEND;
`ifdef MATCTL_CHECK_EN
            if (w_err_set) r_err <= 1'b1;
`endif
          end
        end
        SEND: begin
          if (r_out_valid && bus.out_ready) begin
            if (r_ocnt == 2'd3) begin
              r_out_valid <= 1'b0;
              r_in_ready  <= 1'b1;
              r_cnt       <= '0;
              r_state     <= LOAD;
            end else begin
              r_ocnt     <= r_ocnt + 2'd1;
              r_out_data <= r_res[23:16];
              r_res      <= {r_res[23:0], 8'h00};
            end
          end
        end
        default: r_state <= LOAD;
      endcase
    end
  end

  logic w_unused;
  assign w_unused = w_err_set;
endmodule

// File: tb/tb_matrix2x2_stream_ctrl.sv
// Randomized self-checking bench for matrix2x2_stream_ctrl.
// Includes a behavioural multiplier with a 4-edge latency.
module tb_matrix2x2_stream_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   bad_mul = 1'b0;

  matrix2x2_stream_ctrl_if bus ();

  matrix2x2_stream_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef logic [7:0] byte8_t [8];

  function automatic logic [31:0] mm(
    input logic [31:0] pa,
    input logic [31:0] pb
  );
    int a[2][2];
    int b[2][2];
    logic [31:0] r;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        a[i][j] = int'(pa[31-8*(2*i+j) -: 8]);
        b[i][j] = int'(pb[31-8*(2*i+j) -: 8]);
      end
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        r[31-8*(2*i+j) -: 8] =
          8'((a[i][0] * b[0][j] + a[i][1] * b[1][j]) % 256);
    return r;
  endfunction

  // multiplier: result valid 4 edges after reset release
  int mlat;
  always @(posedge clk) begin
    if (!bus.mat_rst_n) begin
      mlat        <= 0;
      bus.mat_res <= '0;
    end else begin
      if (mlat < 4) mlat <= mlat + 1;
      if (mlat == 3)
        bus.mat_res <= bad_mul ? 32'hDEADBEEF
                               : mm(bus.mat_a, bus.mat_b);
    end
  end

  task automatic chk(
    input string tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int g;
    if (gaps) begin
      bus.in_valid = 1'b0;
      repeat ($urandom_range(0, 3)) tick();
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    g = 0;
    while (!bus.in_ready && g < 50) begin
      tick();
      g++;
    end
    chk("in_acc_tmo", 64'(g < 50), 64'd1);
    tick();
    bus.in_valid = 1'b0;
    bus.in_data  = $urandom;
  endtask

  function automatic logic [31:0] ref_res(input byte8_t e);
    int a[4];
    int b[4];
    logic [31:0] r;
    for (int k = 0; k < 4; k++) begin
      a[k] = int'(e[k]);
      b[k] = int'(e[k+4]);
    end
    r[31:24] = 8'((a[0]*b[0] + a[1]*b[2]) % 256);
    r[23:16] = 8'((a[0]*b[1] + a[1]*b[3]) % 256);
    r[15:8]  = 8'((a[2]*b[0] + a[3]*b[2]) % 256);
    r[7:0]   = 8'((a[2]*b[1] + a[3]*b[3]) % 256);
    return r;
  endfunction

  task automatic load_mat(input byte8_t e, input bit gaps);
    for (int k = 0; k < 8; k++) begin
      send_byte(e[k], gaps);
      if (k == 0) chk("err_clr_b0", 64'(bus.err), 64'd0);
    end
    chk("mat_a", 64'(bus.mat_a),
        64'({e[0], e[1], e[2], e[3]}));
    chk("mat_b", 64'(bus.mat_b),
        64'({e[4], e[5], e[6], e[7]}));
    chk("rst_n_hi", 64'(bus.mat_rst_n), 64'd1);
    chk("in_rdy_lo", 64'(bus.in_ready), 64'd0);
  endtask

  task automatic run_mat(
    input byte8_t e,
    input bit gaps,
    input bit stall
  );
    logic [31:0] exp;
    logic [7:0]  hold;
    int cyc;
    int hi;
    exp = bad_mul ? 32'hDEADBEEF : ref_res(e);
    load_mat(e, gaps);
    cyc = 0;
    hi  = 1;
    while (!bus.out_valid && cyc < 20) begin
      tick();
      cyc++;
      if (bus.mat_rst_n) hi++;
    end
    chk("latency", 64'(cyc), 64'd5);
    chk("rst_n_width", 64'(hi), 64'd5);
    chk("a_held", 64'(bus.mat_a),
        64'({e[0], e[1], e[2], e[3]}));
`ifdef MATCTL_CHECK_EN
    chk("err_cap", 64'(bus.err), 64'(bad_mul));
`else
    chk("err_tie", 64'(bus.err), 64'd0);
`endif
    for (int j = 0; j < 4; j++) begin
      if (stall) begin
        bus.out_ready = 1'b0;
        hold = bus.out_data;
        repeat (3) begin
          tick();
          chk("stall_data", 64'(bus.out_data), 64'(hold));
          chk("stall_vld", 64'(bus.out_valid), 64'd1);
        end
      end
      bus.out_ready = 1'b1;
      chk("out_vld", 64'(bus.out_valid), 64'd1);
      chk("out_byte", 64'(bus.out_data),
          64'(exp[31-8*j -: 8]));
      tick();
    end
    chk("end_vld", 64'(bus.out_valid), 64'd0);
    chk("end_in_rdy", 64'(bus.in_ready), 64'd1);
  endtask

  byte8_t m;

  initial begin
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) tick();
    chk("rst_in_rdy", 64'(bus.in_ready), 64'd0);
    chk("rst_rst_n", 64'(bus.mat_rst_n), 64'd0);
    chk("rst_vld", 64'(bus.out_valid), 64'd0);
    chk("rst_data", 64'(bus.out_data), 64'd0);
    chk("rst_ab", {bus.mat_a, bus.mat_b}, 64'd0);
    chk("rst_err", 64'(bus.err), 64'd0);
    #2 rst = 1'b1;
    tick();
    chk("rel_in_rdy", 64'(bus.in_ready), 64'd1);

    m = '{8'h01, 8'h02, 8'h03, 8'h04,
          8'h05, 8'h06, 8'h07, 8'h08};
    run_mat(m, 1'b0, 1'b0);

    m = '{default: 8'h10};
    run_mat(m, 1'b0, 1'b0);
    chk("ovf_err", 64'(bus.err), 64'd0);

    m = '{8'h01, 8'h02, 8'h03, 8'h04,
          8'h05, 8'h06, 8'h07, 8'h08};
    run_mat(m, 1'b1, 1'b1);

    load_mat(m, 1'b0);
    repeat (2) tick();
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_n", 64'(bus.mat_rst_n), 64'd0);
    chk("mid_vld", 64'(bus.out_valid), 64'd0);
    chk("mid_in_rdy", 64'(bus.in_ready), 64'd0);
    repeat (2) tick();
    #2 rst = 1'b1;
    tick();
    chk("mid_rel_rdy", 64'(bus.in_ready), 64'd1);
    chk("mid_no_out", 64'(bus.out_valid), 64'd0);
    m = '{8'h09, 8'h0A, 8'h0B, 8'h0C,
          8'h0D, 8'h0E, 8'h0F, 8'h11};
    run_mat(m, 1'b0, 1'b0);

    m = '{8'h01, 8'h00, 8'h00, 8'h01,
          8'h05, 8'h06, 8'h07, 8'h08};
    run_mat(m, 1'b0, 1'b0);
    m = '{8'h02, 8'h00, 8'h00, 8'h02,
          8'h01, 8'h02, 8'h03, 8'h04};
    run_mat(m, 1'b0, 1'b0);

`ifdef MATCTL_CHECK_EN
    bad_mul = 1'b1;
    m = '{8'h01, 8'h02, 8'h03, 8'h04,
          8'h05, 8'h06, 8'h07, 8'h08};
    run_mat(m, 1'b0, 1'b0);
    chk("err_sticky", 64'(bus.err), 64'd1);
    bad_mul = 1'b0;
    run_mat(m, 1'b0, 1'b0);
`endif

    for (int t = 0; t < 12; t++) begin
      for (int k = 0; k < 8; k++) m[k] = 8'($urandom);
      run_mat(m, 1'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
